// File: rtl/axi_pkg.sv
// Shared AXI encodings, master FSM states and a transfer-size helper
// for the burst master and its read-beat tracker.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // AxSIZE encoding for a full-width beat: log2 of the bytes per beat.
    function automatic logic [2:0] size_of(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 master-port signal bundle (AR, R, AW, W, B) with master/slave views.
interface axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
);

    // Every channel transfers on a rising edge where VALID and READY are both
    // high; a source holds VALID and its payload stable until that edge and
    // never lowers VALID before it, while READY may change at any time.
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [LEN_W-1:0]    ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

endinterface

// File: rtl/axi_rd_beat_tracker.sv
// Counts read beats of one burst, flags RLAST/count disagreement and keeps a
// sticky error covering RRESP, RID and RLAST placement.
module axi_rd_beat_tracker
    import axi_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int LEN_W     = 4,
    parameter int BURST_LEN = 4,
    parameter int MST_ID    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             beat,
    input  logic [ID_W-1:0]  rid,
    input  logic             rresp_err,
    input  logic             rlast,
    output logic [LEN_W-1:0] beat_idx,
    output logic             overrun,
    output logic             err_now
);

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(BURST_LEN - 1);

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             err_q, err_d;
    logic             beat_err;

    assign beat_err = rresp_err
                    | (rid != ID_W'(MST_ID))
                    | (rlast & (cnt_q != LAST_IDX));
    assign err_now  = err_q | beat_err;
    assign beat_idx = cnt_q;
    assign overrun  = ovr_q;

    always_comb begin
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        err_d = err_q;
        if (start) begin
            cnt_d = '0;
            ovr_d = 1'b0;
            err_d = 1'b0;
        end else if (beat) begin
            cnt_d = cnt_q + LEN_W'(1);
            err_d = err_now;
            // The counter may wrap while dropping surplus beats, so overrun is
            // remembered explicitly rather than derived from the count.
            if (!ovr_q && (cnt_q == LAST_IDX) && !rlast) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovr_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/axi_burst_master.sv
// Turns one CPU memory request into one AXI4 transaction: burst-aligned INCR
// line-fill reads returned beat by beat, or single-beat strobed writes.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MST_ID    = 0,
    parameter int BURST_LEN = 4,
    parameter int LEN_W     = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [LEN_W-1:0]    rsp_beat,
    output logic                rsp_last,
    output logic                rsp_err,
    output logic                busy,
    output state_e              dbg_state,
    axi_burst_master_if.master  axi
);

    localparam logic [2:0]        AXSIZE      = size_of(DATA_W);
    localparam int                BEAT_ALIGN  = int'(size_of(DATA_W));
    localparam int                BURST_ALIGN = $clog2(BURST_LEN) + BEAT_ALIGN;
    localparam logic [ADDR_W-1:0] BEAT_MASK   = ~((ADDR_W'(1) << BEAT_ALIGN) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] BURST_MASK  = ~((ADDR_W'(1) << BURST_ALIGN) - ADDR_W'(1));

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q, w_pend_d;
    logic                werr_q, werr_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [LEN_W-1:0]    rsp_beat_q, rsp_beat_d;
    logic                rsp_last_q, rsp_last_d;
    logic                rsp_err_q, rsp_err_d;

    logic                trk_start;
    logic                r_beat;
    logic [LEN_W-1:0]    trk_idx;
    logic                trk_ovr;
    logic                trk_err;

    assign r_beat = (state_q == ST_R) & axi.RVALID;

    axi_rd_beat_tracker #(
        .ID_W      (ID_W),
        .LEN_W     (LEN_W),
        .BURST_LEN (BURST_LEN),
        .MST_ID    (MST_ID)
    ) u_rd_beat_tracker (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .start     (trk_start),
        .beat      (r_beat),
        .rid       (axi.RID),
        .rresp_err (axi.RRESP[1]),
        .rlast     (axi.RLAST),
        .beat_idx  (trk_idx),
        .overrun   (trk_ovr),
        .err_now   (trk_err)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        werr_d      = werr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_beat_d  = '0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        trk_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    werr_d  = 1'b0;
                    if (!req_write) begin
                        trk_start = 1'b1;
                        state_d   = ST_AR;
                    end else if (req_wstrb == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = ST_WR;
                    end
                end
            end

            ST_AR: begin
                if (axi.ARREADY) begin
                    state_d = ST_R;
                end
            end

            ST_R: begin
                if (axi.RVALID) begin
                    if (!trk_ovr) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = axi.RDATA;
                        rsp_beat_d  = trk_idx;
                        rsp_last_d  = axi.RLAST;
                        rsp_err_d   = axi.RLAST & trk_err;
                    end else if (axi.RLAST) begin
                        // Late RLAST after the full burst was forwarded:
                        // close the request with an error and no data.
                        rsp_valid_d = 1'b1;
                        rsp_beat_d  = trk_idx;
                        rsp_last_d  = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                    if (axi.RLAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WR: begin
                aw_pend_d = aw_pend_q & ~axi.AWREADY;
                w_pend_d  = w_pend_q & ~axi.WREADY;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = ST_B;
                end
            end

            ST_B: begin
                if (axi.BVALID) begin
                    werr_d  = axi.BRESP[1] | (axi.BID != ID_W'(MST_ID));
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                rsp_valid_d = 1'b1;
                rsp_last_d  = 1'b1;
                rsp_err_d   = werr_q;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            werr_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_beat_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            werr_q      <= werr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_beat_q  <= rsp_beat_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // req_ready is gated by the reset input so it stays low while reset is held.
    assign req_ready = (state_q == ST_IDLE) & ARESETn;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_beat  = rsp_beat_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;

    assign axi.ARID    = ID_W'(MST_ID);
    assign axi.ARADDR  = addr_q & BURST_MASK;
    assign axi.ARLEN   = LEN_W'(BURST_LEN - 1);
    assign axi.ARSIZE  = AXSIZE;
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARVALID = (state_q == ST_AR);
    assign axi.RREADY  = (state_q == ST_R);

    assign axi.AWID    = ID_W'(MST_ID);
    assign axi.AWADDR  = addr_q & BEAT_MASK;
    assign axi.AWLEN   = '0;
    assign axi.AWSIZE  = AXSIZE;
    assign axi.AWBURST = BURST_INCR;
    assign axi.AWVALID = (state_q == ST_WR) & aw_pend_q;

    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WLAST   = 1'b1;
    assign axi.WVALID  = (state_q == ST_WR) & w_pend_q;
    assign axi.BREADY  = (state_q == ST_B);

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: table of normal transactions plus
// hand-written corner sequences, with a response scoreboard.
module tb_axi_burst_master;
    import axi_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int LEN_W     = 4;
    localparam int BURST_LEN = 4;
    localparam int MST_ID    = 0;
    localparam int RW        = 2 + LEN_W + DATA_W;

    localparam logic [RW-1:0] M_ALL    = '1;
    localparam logic [RW-1:0] M_LE     = {2'b11, {(RW-2){1'b0}}};
    localparam logic [RW-1:0] M_NOBEAT = {2'b11, {LEN_W{1'b0}}, {DATA_W{1'b1}}};

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_write = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [DATA_W-1:0]   req_wdata = '0;
    logic [DATA_W/8-1:0] req_wstrb = '0;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [LEN_W-1:0]    rsp_beat;
    logic                rsp_last;
    logic                rsp_err;
    logic                busy;
    state_e              dbg_state;

    axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) axi();

    axi_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MST_ID(MST_ID),
        .BURST_LEN(BURST_LEN), .LEN_W(LEN_W)
    ) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_beat(rsp_beat),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
        .dbg_state(dbg_state), .axi(axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rsp_cyc = -1;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] msk_q[$];

    typedef struct {
        logic                wr;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wstrb;
        logic [1:0]          resp;
        logic [ID_W-1:0]     id;
        logic [ADDR_W-1:0]   exp_addr;
        logic                exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input logic last, input logic err, input logic [LEN_W-1:0] beat,
                              input logic [DATA_W-1:0] data, input logic [RW-1:0] msk);
        exp_q.push_back({last, err, beat, data});
        msk_q.push_back(msk);
    endtask

    // Advance to the next falling edge and score any response present there.
    task automatic tick();
        logic [RW-1:0] a, e, m;
        @(negedge clk);
        cyc++;
        if (rsp_valid === 1'b1) begin
            last_rsp_cyc = cyc;
            a = {rsp_last, rsp_err, rsp_beat, rsp_rdata};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %0h expected none (cycle %0d)", a, cyc);
            end else begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                check("rsp", 64'(a & m), 64'(e & m));
            end
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return axi.ARVALID;
            1:       return axi.RREADY;
            2:       return axi.BREADY;
            default: return req_ready;
        endcase
    endfunction

    task automatic wait_for(input int w, input string name);
        int n = 0;
        while (sig(w) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({"wait_", name}, 64'(sig(w)), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'(0));
        check("idle_ready", 64'({req_ready, busy}), 64'(2'b10));
    endtask

    task automatic send_req(input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [DATA_W/8-1:0] wstrb,
                            output int acc_cyc);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        wait_for(3, "req_ready");
        acc_cyc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] exp_araddr,
                           input int nbeats, input int last_at, input logic [1:0] resp,
                           input logic [ID_W-1:0] rid, input logic [DATA_W-1:0] base);
        int acc;
        logic err, ovr, be, lst;
        send_req(1'b0, addr, '0, '0, acc);
        check("rd_busy", 64'(busy), 64'(1));
        wait_for(0, "arvalid");
        check("araddr", 64'(axi.ARADDR), 64'(exp_araddr));
        check("ar_len_size_burst_id",
              64'({axi.ARLEN, axi.ARSIZE, axi.ARBURST, axi.ARID}),
              64'({4'd3, 3'd2, BURST_INCR, 4'(MST_ID)}));
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        check("arvalid_drop", 64'(axi.ARVALID), 64'(0));
        err = 1'b0;
        ovr = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            lst = (i == last_at);
            be  = resp[1] | (rid != ID_W'(MST_ID)) | (lst && i != BURST_LEN - 1);
            axi.RVALID = 1'b1;
            axi.RDATA  = base + DATA_W'(i);
            axi.RLAST  = lst;
            axi.RRESP  = resp;
            axi.RID    = rid;
            if (!ovr) begin
                err = err | be;
                expect_rsp(lst, lst & err, LEN_W'(i), base + DATA_W'(i), M_ALL);
                if (i == BURST_LEN - 1 && !lst) ovr = 1'b1;
            end else if (lst) begin
                expect_rsp(1'b1, 1'b1, '0, '0, M_NOBEAT);
            end
            wait_for(1, "rready");
            tick();
        end
        axi.RVALID = 1'b0;
        axi.RLAST  = 1'b0;
        drain();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                            input logic [DATA_W/8-1:0] wstrb, input int aw_delay, input int w_delay,
                            input logic [1:0] bresp, input logic [ID_W-1:0] bid,
                            input logic [ADDR_W-1:0] exp_awaddr, input logic exp_err);
        int acc;
        int k = 0;
        logic aw_done = 1'b0;
        logic w_done = 1'b0;
        send_req(1'b1, addr, wdata, wstrb, acc);
        check("wr_entry_valids", 64'({axi.AWVALID, axi.WVALID}), 64'(2'b11));
        check("awaddr", 64'(axi.AWADDR), 64'(exp_awaddr));
        check("aw_len_size_burst_id",
              64'({axi.AWLEN, axi.AWSIZE, axi.AWBURST, axi.AWID}),
              64'({4'd0, 3'd2, BURST_INCR, 4'(MST_ID)}));
        check("w_data_strb_last", 64'({axi.WDATA, axi.WSTRB, axi.WLAST}), 64'({wdata, wstrb, 1'b1}));
        while (!(aw_done && w_done) && k < 50) begin
            axi.AWREADY = (k >= aw_delay);
            axi.WREADY  = (k >= w_delay);
            check(aw_done ? "awvalid_after_hs" : "awvalid_held", 64'(axi.AWVALID), 64'(!aw_done));
            check(w_done ? "wvalid_after_hs" : "wvalid_held", 64'(axi.WVALID), 64'(!w_done));
            if (axi.AWVALID && axi.AWREADY) aw_done = 1'b1;
            if (axi.WVALID && axi.WREADY) w_done = 1'b1;
            tick();
            k++;
        end
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        check("aw_w_both_done", 64'({aw_done, w_done}), 64'(2'b11));
        axi.BVALID = 1'b1;
        axi.BRESP  = bresp;
        axi.BID    = bid;
        expect_rsp(1'b1, exp_err, '0, '0, M_LE);
        wait_for(2, "bready");
        check("b_no_aw_w", 64'({axi.AWVALID, axi.WVALID}), 64'(0));
        tick();
        axi.BVALID = 1'b0;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        axi.ARREADY = 1'b0; axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = RESP_OKAY; axi.RLAST = 1'b0; axi.RID = '0;
        axi.BVALID = 1'b0; axi.BRESP = RESP_OKAY; axi.BID = '0;

        vecs[0] = '{1'b0, 32'h0000_1034, 32'h0,         4'h0,    RESP_OKAY,   4'd0, 32'h0000_1030, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 4'b1100, RESP_OKAY,   4'd0, 32'h0000_2000, 1'b0};
        vecs[2] = '{1'b0, 32'h1234_567F, 32'h0,         4'h0,    RESP_SLVERR, 4'd0, 32'h1234_5670, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_4007, 32'h1234_5678, 4'b0001, RESP_SLVERR, 4'd0, 32'h0000_4004, 1'b1};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'h0,    RESP_OKAY,   4'd3, 32'hFFFF_FFF0, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'b1111, RESP_DECERR, 4'd0, 32'h0000_0008, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0013, 32'h0BAD_0BAD, 4'b0110, RESP_OKAY,   4'd2, 32'h0000_0010, 1'b1};
        vecs[7] = '{1'b0, 32'h0000_0047, 32'h0,         4'h0,    RESP_EXOKAY, 4'd0, 32'h0000_0040, 1'b0};

        // Reset state.
        #2;
        check("rst_ready_busy_rsp", 64'({req_ready, busy, rsp_valid, rsp_last, rsp_err}), 64'(0));
        check("rst_valids_readies",
              64'({axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY}), 64'(0));
        check("rst_addr_data", 64'({axi.ARADDR, axi.AWADDR}), 64'(0));
        check("rst_wdata_strb", 64'({axi.WDATA, axi.WSTRB}), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 64'(req_ready), 64'(1));

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 0,
                         vecs[i].resp, vecs[i].id, vecs[i].exp_addr, vecs[i].exp_err);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp_addr, BURST_LEN, BURST_LEN - 1,
                        vecs[i].resp, vecs[i].id, 32'h0000_00A0 + 32'(i) * 32'h1000);
            end
        end

        // AW accepted three cycles before W, then the reverse ordering.
        do_write(32'h0000_2002, 32'hDEAD_BEEF, 4'b1100, 0, 3, RESP_OKAY, 4'd0, 32'h0000_2000, 1'b0);
        do_write(32'h0000_3000, 32'h5555_AAAA, 4'b0011, 2, 0, RESP_OKAY, 4'd0, 32'h0000_3000, 1'b0);

        // RLAST on beat 1, then RLAST missing on beat 3 and arriving on beat 5.
        do_read(32'h0000_5000, 32'h0000_5000, 2, 1, RESP_OKAY, 4'd0, 32'h0000_0B00);
        do_read(32'h0000_6008, 32'h0000_6000, 6, 5, RESP_OKAY, 4'd0, 32'h0000_0C00);

        // Write with no strobes: no AXI traffic, response two cycles after acceptance.
        expect_rsp(1'b1, 1'b0, '0, '0, M_LE);
        send_req(1'b1, 32'h0000_7000, 32'h1111_2222, 4'b0000, acc);
        for (int i = 0; i < 3; i++) begin
            check("wstrb0_no_aw_w", 64'({axi.AWVALID, axi.WVALID, axi.ARVALID}), 64'(0));
            tick();
        end
        check("wstrb0_latency", 64'(last_rsp_cyc), 64'(acc + 2));
        drain();

        // Reset during the R phase after beat 1.
        send_req(1'b0, 32'h0000_8010, '0, '0, acc);
        wait_for(0, "arvalid_rst");
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.RVALID = 1'b1; axi.RDATA = 32'h0000_0D00 + 32'(i); axi.RLAST = 1'b0;
            axi.RRESP = RESP_OKAY; axi.RID = 4'(MST_ID);
            expect_rsp(1'b0, 1'b0, LEN_W'(i), 32'h0000_0D00 + 32'(i), M_ALL);
            wait_for(1, "rready_rst");
            tick();
        end
        axi.RVALID = 1'b0;
        check("pre_rst_pending", 64'(exp_q.size()), 64'(0));
        check("pre_rst_in_r", 64'(axi.RREADY), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({req_ready, busy, rsp_valid, axi.ARVALID, axi.RREADY,
                                     axi.AWVALID, axi.WVALID, axi.BREADY}), 64'(0));
        check("midrst_addr", 64'(axi.ARADDR), 64'(0));
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 64'({req_ready, busy}), 64'(2'b10));
        do_read(32'h0000_9034, 32'h0000_9030, BURST_LEN, BURST_LEN - 1, RESP_OKAY, 4'd0, 32'h0000_0E00);
        do_write(32'h0000_A001, 32'h7777_8888, 4'b1000, 1, 1, RESP_SLVERR, 4'd0, 32'h0000_A000, 1'b1);

        for (int i = 0; i < 4; i++) tick();
        check("final_pending", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Parametrised AXI4 master port that turns one CPU-side memory request into one AXI transaction.
- Reads are fixed-length INCR bursts (line fill), returned beat-by-beat. Writes are single-beat with byte strobes.
- AW and W are issued concurrently. The block reports protocol errors and response errors.
- One instance per CPU memory port (IM, DM); it sits between the core and the AXI interconnect master slot.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; power of two, at least 32.
- ID_W, 4, AXI ID width.
- MST_ID, 0, constant driven on ARID/AWID and expected on RID/BID.
- BURST_LEN, 4, read beats per request; power of two, 1..16.
- LEN_W, 4, AXI LEN field width.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte strobes
- rsp_valid  out  1  one-cycle pulse per returned beat or write completion
- rsp_rdata  out  DATA_W  read beat data
- rsp_beat  out  LEN_W  beat index within the burst
- rsp_last  out  1  final response of the request
- rsp_err  out  1  error flag, valid with rsp_last
- busy  out  1  high while state != IDLE; CPU stall source
- AR channel: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID (out); ARREADY (in)
- R channel: RID, RDATA, RRESP, RLAST, RVALID (in); RREADY (out)
- AW channel: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID (out); AWREADY (in)
- W channel: WDATA, WSTRB, WLAST, WVALID (out); WREADY (in)
- B channel: BID, BRESP, BVALID (in); BREADY (out)

Behaviour:
- Reset:
  - State IDLE.
  - All VALID/READY outputs 0; addresses, data, strobes 0.
  - rsp_* all 0; busy 0.
  - req_ready = 1 once ARESETn is high.
- Reset asserted mid-transaction: abandon the transaction immediately; emit no response.
- States: IDLE, AR, R, WR, B, DONE.
- IDLE:
  - req_ready=1; the handshake latches write, addr, wdata, wstrb.
  - Read → AR.
  - Write with wstrb==0 → DONE. No AXI traffic; completes successfully (err 0).
  - Write with wstrb!=0 → WR.
- AR:
  - ARADDR = addr with low log2(BURST_LEN*DATA_W/8) bits cleared (burst-aligned).
  - ARLEN=BURST_LEN-1; ARSIZE=log2(DATA_W/8); ARBURST=2'b01; ARID=MST_ID.
  - ARVALID=1; all AR fields stable until ARREADY. Go to R on the handshake.
- R:
  - RREADY=1.
  - Each beat is registered: one cycle later rsp_valid=1, rsp_rdata=RDATA, rsp_beat=counter. Counter increments on every beat.
  - Sticky error is set by any of: RRESP[1]=1; RID!=MST_ID; RLAST on a beat with counter!=BURST_LEN-1.
  - RLAST arriving early: that beat is the last response (rsp_last=1, rsp_err=1).
  - Missing RLAST on beat BURST_LEN-1: that beat is forwarded without rsp_last. Keep RREADY high and drop further beats until RLAST. The RLAST beat produces a single response: rsp_valid with rsp_last=1, rsp_err=1, rsp_rdata=0.
  - Leave R on the RLAST handshake → IDLE. The response appears on the next cycle.
- WR:
  - AWADDR = addr with low log2(DATA_W/8) bits cleared; AWLEN=0; AWSIZE/AWBURST/AWID as for reads.
  - WDATA=wdata; WSTRB=wstrb; WLAST=1.
  - AWVALID and WVALID are both asserted on entry. Each drops independently after its own handshake and never re-asserts.
  - When both handshakes have completed (same cycle or different cycles) → B.
- B:
  - BREADY=1.
  - On BVALID → DONE; err = BRESP[1] or BID!=MST_ID.
- DONE: one cycle with rsp_valid=1, rsp_last=1, rsp_err=err; then → IDLE.
- req_ready=0 in every state except IDLE. There is no response back-pressure: the consumer must accept every rsp_valid.
- Throughput: a new request may be accepted in the cycle after the final response.

Decomposition:
- Package axi_pkg holds: BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, the state enum, and a function size_of(DATA_W).
- Natural sub-module: axi_rd_beat_tracker, covering the beat counter, RLAST/count mismatch checks and sticky error.
- Everything else stays flat.

Test Plan:
- Read, addr=0x0000_1034, BURST_LEN=4, slave RDATA 0xA0..0xA3, OKAY → ARADDR=0x1030, ARLEN=3, four rsp_valid with beats 0..3, rsp_last on beat 3, rsp_err=0.
- Write, addr=0x2002, wdata=0xDEADBEEF, wstrb=4'b1100; AWREADY 3 cycles before WREADY → AWVALID drops first, WVALID held; single response with rsp_err=0 after BVALID.
- Read with RLAST on beat 1 → two responses, second has rsp_last=1, rsp_err=1; req_ready returns 1.
- Read with RLAST missing on beat 3, arriving on beat 5 → beats 0..3 forwarded, beat 4 dropped, beat 5 gives a single response with rsp_last=1, rsp_err=1, rsp_rdata=0.
- Write with wstrb=0 → no AWVALID/WVALID; rsp_valid with rsp_last=1 exactly 2 cycles after acceptance.
- ARESETn low during R after beat 1, then released → all outputs at reset values, no further rsp_valid; next read completes normally; BRESP=SLVERR on a later write gives rsp_err=1.
